issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 166 ++++++++++++++++
 tb/tb_issue_scoreboard.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : Register busy-table scoreboard gating in-order issue from
//               decode to execute. It detects RAW/WAW hazards, stalls decode
//               and counts stall cycles. The optional macro
//               SCOREBOARD_BYPASS_EN lets a same-cycle writeback unblock
//               dependent sources.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_IDSUE_valid,
    input  logic [6:0]  i_IDSUE_opcode,
    input  logic [4:0]  i_IDSUE_rs1,
    input  logic [4:0]  i_IDSUE_rs2,
    input  logic [4:0]  i_IDSUE_rd,
    output logic        o_IDSUE_stall,
    output logic        o_SUEEX_valid,
    input  logic        i_SUEEX_ready,
    input  logic        i_WB_valid,
    input  logic [4:0]  i_WB_rd,
    input  logic        i_flush,
    output logic [15:0] o_stall_cnt
);

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_HAZARD = 2'd1;
    localparam logic [1:0] c_ST_FLUSH  = 2'd2;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [31:0] r_busy;
    logic [1:0]  r_state;
    logic [15:0] r_stall_cnt;

    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_writes_rd;
    logic        w_rd_wr;
    logic [31:0] w_wb_clr;
    logic [31:0] w_bypass;
    logic [31:0] w_src_tbl;
    logic [31:0] w_set;
    logic [31:0] w_busy_nxt;
    logic        w_hazard;
    logic        w_hazard_nxt;
    logic        w_issue;
    logic        w_taken;
    logic        w_stall;
    logic [1:0]  w_state_nxt;

    // Unknown opcodes fall through as no-source/no-dest so they never block.
    always_comb begin
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_writes_rd = 1'b0;
        case (i_IDSUE_opcode)
            c_OPC_LUI, c_OPC_AUIPC, c_OPC_JAL: begin
                w_writes_rd = 1'b1;
            end
            c_OPC_OP_IMM, c_OPC_JALR, c_OPC_LOAD: begin
                w_use_rs1   = 1'b1;
                w_writes_rd = 1'b1;
            end
            c_OPC_OP: begin
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_writes_rd = 1'b1;
            end
            c_OPC_BRANCH, c_OPC_STORE: begin
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
            default: begin
                w_use_rs1   = 1'b0;
                w_use_rs2   = 1'b0;
                w_writes_rd = 1'b0;
            end
        endcase
    end

    assign w_rd_wr  = w_writes_rd && (i_IDSUE_rd != 5'd0);
    assign w_wb_clr = i_WB_valid ? (32'd1 << i_WB_rd) : 32'd0;

`ifdef SCOREBOARD_BYPASS_EN
    assign w_bypass = w_wb_clr;
`else
    assign w_bypass = 32'd0;
`endif

    // Bypass only relaxes source reads; WAW still uses the registered table.
    assign w_src_tbl = r_busy & ~w_bypass;

    assign w_hazard = (w_use_rs1 && w_src_tbl[i_IDSUE_rs1]) ||
                      (w_use_rs2 && w_src_tbl[i_IDSUE_rs2]) ||
                      (w_rd_wr   && r_busy[i_IDSUE_rd]);

    assign w_issue = !rst && (r_state == c_ST_RUN) && i_IDSUE_valid &&
                     !w_hazard && !i_flush;
    assign w_taken = w_issue && i_SUEEX_ready;
    assign w_stall = !rst && i_IDSUE_valid && !w_taken && !i_flush;

    assign w_set      = (w_taken && w_rd_wr) ? (32'd1 << i_IDSUE_rd) : 32'd0;
    assign w_busy_nxt = ((r_busy & ~w_wb_clr) | w_set) & ~32'd1;

    // Hazard seen against next cycle's table, so RUN is re-entered exactly
    // when the held instruction becomes issuable.
    assign w_hazard_nxt = (w_use_rs1 && w_busy_nxt[i_IDSUE_rs1]) ||
                          (w_use_rs2 && w_busy_nxt[i_IDSUE_rs2]) ||
                          (w_rd_wr   && w_busy_nxt[i_IDSUE_rd]);

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = c_ST_FLUSH;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (i_IDSUE_valid && !w_taken && w_hazard_nxt)
                        w_state_nxt = c_ST_HAZARD;
                end
                c_ST_HAZARD: begin
                    if (!(i_IDSUE_valid && w_hazard_nxt))
                        w_state_nxt = c_ST_RUN;
                end
                c_ST_FLUSH: begin
                    w_state_nxt = c_ST_RUN;
                end
                default: begin
                    w_state_nxt = c_ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 32'd0;
            r_state     <= c_ST_RUN;
            r_stall_cnt <= 16'd0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_SUEEX_valid = w_issue;
    assign o_IDSUE_stall = w_stall;
    assign o_stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scoreboard
// Description : Directed self-checking bench for issue_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

    localparam logic [6:0] c_OP_IMM = 7'h13;
    localparam logic [6:0] c_OP     = 7'h33;
    localparam logic [6:0] c_STORE  = 7'h23;
    localparam logic [6:0] c_LUI    = 7'h37;
    localparam logic [6:0] c_UNK    = 7'h7F;

    logic        clk;
    logic        rst;
    logic        i_IDSUE_valid;
    logic [6:0]  i_IDSUE_opcode;
    logic [4:0]  i_IDSUE_rs1;
    logic [4:0]  i_IDSUE_rs2;
    logic [4:0]  i_IDSUE_rd;
    logic        o_IDSUE_stall;
    logic        o_SUEEX_valid;
    logic        i_SUEEX_ready;
    logic        i_WB_valid;
    logic [4:0]  i_WB_rd;
    logic        i_flush;
    logic [15:0] o_stall_cnt;

    int          checks;
    int          errors;
    logic [15:0] exp_cnt;

    issue_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .i_IDSUE_valid  (i_IDSUE_valid),
        .i_IDSUE_opcode (i_IDSUE_opcode),
        .i_IDSUE_rs1    (i_IDSUE_rs1),
        .i_IDSUE_rs2    (i_IDSUE_rs2),
        .i_IDSUE_rd     (i_IDSUE_rd),
        .o_IDSUE_stall  (o_IDSUE_stall),
        .o_SUEEX_valid  (o_SUEEX_valid),
        .i_SUEEX_ready  (i_SUEEX_ready),
        .i_WB_valid     (i_WB_valid),
        .i_WB_rd        (i_WB_rd),
        .i_flush        (i_flush),
        .o_stall_cnt    (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks issue/stall/counter mid-cycle; the counter model advances when a stall is expected.
    task automatic expect_io(input string tag, input logic ev, input logic es);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, o_SUEEX_valid}, {31'd0, ev});
        chk({tag, "_stall"}, {31'd0, o_IDSUE_stall}, {31'd0, es});
        chk({tag, "_cnt"}, {16'd0, o_stall_cnt}, {16'd0, exp_cnt});
        if (es && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [6:0] opc, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d);
        i_IDSUE_valid  = v;
        i_IDSUE_opcode = opc;
        i_IDSUE_rs1    = s1;
        i_IDSUE_rs2    = s2;
        i_IDSUE_rd     = d;
    endtask

    task automatic wb(input logic v, input logic [4:0] d);
        i_WB_valid = v;
        i_WB_rd    = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 16'd0;
        rst = 1'b1;
        i_SUEEX_ready = 1'b1;
        i_flush = 1'b0;
        instr(1'b1, c_OP_IMM, 5'd1, 5'd0, 5'd5);
        wb(1'b0, 5'd0);
        tick();

        // Reset holds outputs low even with a valid instruction present
        expect_io("reset", 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Execute not ready: issue offered but not taken
        i_SUEEX_ready = 1'b0;
        expect_io("not_ready", 1'b1, 1'b1);
        tick();
        i_SUEEX_ready = 1'b1;
        expect_io("addi_x5", 1'b1, 1'b0);
        tick();

        // RAW on x5 held until writeback
        instr(1'b1, c_OP, 5'd5, 5'd1, 5'd6);
        for (int i = 0; i < 3; i++) begin
            expect_io("raw_hold", 1'b0, 1'b1);
            tick();
        end
        wb(1'b1, 5'd5);
        expect_io("raw_wb", 1'b0, 1'b1);
        tick();
        wb(1'b0, 5'd0);
        expect_io("raw_issue", 1'b1, 1'b0);
        tick();
        instr(1'b0, c_OP, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd6);
        expect_io("clr_x6", 1'b0, 1'b0);
        tick();

        // Writeback coincident with a dependent instruction
        instr(1'b1, c_OP_IMM, 5'd1, 5'd0, 5'd5);
        wb(1'b0, 5'd0);
        expect_io("addi_x5_b", 1'b1, 1'b0);
        tick();
        instr(1'b1, c_OP, 5'd5, 5'd1, 5'd6);
        wb(1'b1, 5'd5);
`ifdef SCOREBOARD_BYPASS_EN
        expect_io("bypass_issue", 1'b1, 1'b0);
        tick();
`else
        expect_io("nobypass_wait", 1'b0, 1'b1);
        tick();
        wb(1'b0, 5'd0);
        expect_io("nobypass_issue", 1'b1, 1'b0);
        tick();
`endif
        instr(1'b0, c_OP, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd6);
        expect_io("clr_x6_b", 1'b0, 1'b0);
        tick();
        wb(1'b0, 5'd0);

        // Flush while in HAZARD: no issue, one FLUSH cycle, busy x5 kept
        instr(1'b1, c_OP_IMM, 5'd1, 5'd0, 5'd5);
        expect_io("addi_x5_c", 1'b1, 1'b0);
        tick();
        instr(1'b1, c_OP, 5'd5, 5'd1, 5'd6);
        expect_io("haz_before_flush", 1'b0, 1'b1);
        tick();
        i_flush = 1'b1;
        expect_io("flush_cycle", 1'b0, 1'b0);
        tick();
        i_flush = 1'b0;
        instr(1'b1, c_LUI, 5'd0, 5'd0, 5'd8);
        expect_io("flush_state", 1'b0, 1'b1);
        tick();
        expect_io("after_flush", 1'b1, 1'b0);
        tick();
        instr(1'b1, c_OP, 5'd5, 5'd1, 5'd6);
        expect_io("x5_still_busy", 1'b0, 1'b1);
        tick();
        instr(1'b0, c_OP, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd5);
        expect_io("clr_x5", 1'b0, 1'b0);
        tick();
        wb(1'b1, 5'd8);
        expect_io("clr_x8", 1'b0, 1'b0);
        tick();

        // Set wins over clear on x7
        instr(1'b1, c_OP_IMM, 5'd1, 5'd0, 5'd7);
        wb(1'b1, 5'd7);
        expect_io("set_clr_x7", 1'b1, 1'b0);
        tick();
        wb(1'b0, 5'd0);
        instr(1'b1, c_OP, 5'd7, 5'd0, 5'd9);
        expect_io("x7_busy", 1'b0, 1'b1);
        tick();
        instr(1'b0, c_OP, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd7);
        expect_io("clr_x7", 1'b0, 1'b0);
        tick();
        wb(1'b0, 5'd0);

        // x0 is never busy
        instr(1'b1, c_OP_IMM, 5'd0, 5'd0, 5'd0);
        expect_io("addi_x0_a", 1'b1, 1'b0);
        tick();
        expect_io("addi_x0_b", 1'b1, 1'b0);
        tick();
        instr(1'b1, c_STORE, 5'd0, 5'd0, 5'd0);
        expect_io("store_x0", 1'b1, 1'b0);
        tick();

        // Unknown opcode ignores a busy register
        instr(1'b1, c_OP_IMM, 5'd1, 5'd0, 5'd5);
        expect_io("addi_x5_d", 1'b1, 1'b0);
        tick();
        instr(1'b1, c_UNK, 5'd5, 5'd5, 5'd5);
        expect_io("unknown_op", 1'b1, 1'b0);
        tick();

        // Reset mid-stall discards hazard and counter
        instr(1'b1, c_OP, 5'd5, 5'd1, 5'd6);
        expect_io("pre_rst_stall", 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        expect_io("rst_mid_stall", 1'b0, 1'b0);
        exp_cnt = 16'd0;
        tick();
        rst = 1'b0;
        expect_io("post_rst_issue", 1'b1, 1'b0);
        tick();

        // Long hazard on x6: counter saturates without wrapping
        instr(1'b1, c_OP, 5'd6, 5'd1, 5'd10);
        expect_io("sat_start", 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 65533; i++) tick();
        exp_cnt = 16'hFFFE;
        expect_io("sat_fffe", 1'b0, 1'b1);
        tick();
        expect_io("sat_ffff", 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4470; i++) tick();
        expect_io("sat_hold", 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
